scr1_dmem_copier: RTL and testbench
===================================

SCR1_DMEM_COPIER -- requirements
Module: scr1_dmem_copier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  in  1  block clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cfg_start  in  1  one-cycle job launch strobe.
REQ-005 cfg_src_addr  in  32  source byte address, sampled on an accepted start.
REQ-006 cfg_dst_addr  in  32  destination byte address, sampled on an accepted start.
REQ-007 cfg_len  in  16  number of 32-bit words to copy, sampled on an accepted start.
REQ-008 busy  out  1  high while a job is in progress.
REQ-009 done  out  1  one-cycle pulse when a job ends (success, error or zero length).
REQ-010 err  out  1  sticky error flag; cleared by the next accepted start.
REQ-011 xfer_cnt  out  16  number of words written so far in the current or last job.
REQ-012 dmem_req  out  1  request valid.
REQ-013 dmem_cmd  out  type_scr1_mem_cmd_e  RD or WR.
REQ-014 dmem_width  out  type_scr1_mem_width_e  always WORD.
REQ-015 dmem_addr  out  SCR1_DMEM_AWIDTH  request address.
REQ-016 dmem_wdata  out  SCR1_DMEM_DWIDTH  write data.
REQ-017 dmem_req_ack  in  1  request accepted by the responder.
REQ-018 dmem_rdata  in  SCR1_DMEM_DWIDTH  read data, valid when dmem_resp is RDY_OK.
REQ-019 dmem_resp  in  type_scr1_mem_resp_e  NOTRDY, RDY_OK or RDY_ER.

Function
REQ-020 The block SHALL implement the FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and DONE.
REQ-021 The block SHALL accept cfg_start only in IDLE; a start received in any other state SHALL be ignored.
REQ-022 On an accepted start the block SHALL latch the source address, destination address and length, clear err, and clear xfer_cnt.
REQ-023 On an accepted start the next state SHALL be selected as follows:
- cfg_src_addr[1:0] or cfg_dst_addr[1:0] nonzero: set err, go to DONE, issue no bus transfers.
- cfg_len equal to 0: go to DONE with no bus transfers.
- Otherwise: go to RD_REQ.
REQ-024 In RD_REQ the block SHALL drive dmem_req=1, dmem_cmd=RD and dmem_addr=current source address, holding all of them stable until dmem_req_ack=1; it SHALL then go to RD_WAIT.
REQ-025 In RD_WAIT and WR_WAIT the block SHALL drive dmem_req=0 and SHALL stay in the state while dmem_resp=NOTRDY.
REQ-026 In RD_WAIT, on RDY_OK the block SHALL capture dmem_rdata into a data register and go to WR_REQ.
REQ-027 In WR_REQ the block SHALL drive dmem_req=1, dmem_cmd=WR, dmem_addr=current destination address and dmem_wdata=the data register, holding all of them stable until dmem_req_ack=1; it SHALL then go to WR_WAIT.
REQ-028 In WR_WAIT, on RDY_OK the block SHALL:
- increment xfer_cnt;
- add 4 to both addresses, modulo 2^32 (wrap-around permitted);
- decrement the remaining count, then go to DONE if the remaining count reaches 0, otherwise go to RD_REQ.
REQ-029 RDY_ER in either wait state SHALL set err and go to DONE; xfer_cnt SHALL not increment on an errored write.
REQ-030 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 Only one transaction SHALL be outstanding at a time.
REQ-033 With a responder that acks immediately and answers the following cycle, each word SHALL take 4 cycles, and done SHALL be high 4*N+1 cycles after the start edge.
REQ-034 dmem_width SHALL always be WORD.
REQ-035 When dmem_req=0, dmem_cmd, dmem_addr and dmem_wdata SHALL be don't-care.

Reset
REQ-036 While rst_n=0, at any time including mid-job, the block SHALL immediately force:
- state IDLE;
- dmem_req, busy, done and err to 0;
- xfer_cnt, the address registers, the length register and the data register to 0.
REQ-037 After rst_n is released the block SHALL issue no bus request until an accepted start.

Structure
REQ-038 The memory command, width and response types SHALL come from the existing shared memory-interface package; no new shared typedefs are introduced.
REQ-039 The FSM state enum and the word-stride constant (4) SHALL be local to the module.
REQ-040 The block SHALL be a single module with no sub-modules.

Verification
REQ-041 The bench SHALL cover: src=0x100, dst=0x200, len=3, immediate-ack memory model -> three RD/WR pairs at 0x100/0x200, 0x104/0x204, 0x108/0x208; destination data equals source data; done at cycle 13; xfer_cnt=3; err=0.
REQ-042 The bench SHALL cover: responder holding req_ack=0 for 3 cycles and NOTRDY for 2 cycles -> request fields stable throughout, correct data copied, no extra requests.
REQ-043 The bench SHALL cover: RDY_ER on the second read of a len=4 job -> err=1, xfer_cnt=1, done pulse, no further requests; the next start clears err.
REQ-044 The bench SHALL cover: src=0x102 or len=0 -> done one cycle after start, zero dmem_req cycles; err=1 only for the misaligned case.
REQ-045 The bench SHALL cover: src=0xFFFFFFFC with len=2 -> second read at 0x00000000.
REQ-046 The bench SHALL cover: a start pulsed while busy is ignored, and rst_n asserted mid-WR_REQ -> dmem_req=0 and busy=0 immediately.

Source files
------------

// File: rtl/scr1_memif_pkg.sv
// rtl/scr1_memif_pkg.sv - shared memory-interface types and bus widths
package scr1_memif_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_copier_if.sv
// rtl/scr1_dmem_copier_if.sv - data-memory request/response bus between copier and responder
interface scr1_dmem_copier_if;
  import scr1_memif_pkg::*;

  logic                        dmem_req;
  type_scr1_mem_cmd_e          dmem_cmd;
  type_scr1_mem_width_e        dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata;
  logic                        dmem_req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata;
  type_scr1_mem_resp_e         dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/scr1_dmem_copier.sv
// rtl/scr1_dmem_copier.sv - word-by-word memory copy engine, one outstanding bus transaction
module scr1_dmem_copier
  import scr1_memif_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_src_addr,
  input  logic [31:0] cfg_dst_addr,
  input  logic [15:0] cfg_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] xfer_cnt,
  scr1_dmem_copier_if.master dmem
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  localparam logic [SCR1_DMEM_AWIDTH-1:0] WORD_STRIDE = SCR1_DMEM_AWIDTH'(4);

  state_e                      state_q, state_d;
  logic [SCR1_DMEM_AWIDTH-1:0] src_q, src_d;
  logic [SCR1_DMEM_AWIDTH-1:0] dst_q, dst_d;
  logic [15:0]                 len_q, len_d;
  logic [SCR1_DMEM_DWIDTH-1:0] data_q, data_d;
  logic                        err_q, err_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        req;
  type_scr1_mem_cmd_e          cmd;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    cmd     = SCR1_MEM_CMD_RD;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          src_d = cfg_src_addr;
          dst_d = cfg_dst_addr;
          len_d = cfg_len;
          err_d = 1'b0;
          cnt_d = 16'd0;
          if ((cfg_src_addr[1:0] != 2'b00) || (cfg_dst_addr[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (cfg_len == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        req = 1'b1;
        if (dmem.dmem_req_ack) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (dmem.dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
          data_d  = dmem.dmem_rdata;
          state_d = ST_WR_REQ;
        end else if (dmem.dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        req = 1'b1;
        cmd = SCR1_MEM_CMD_WR;
        if (dmem.dmem_req_ack) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (dmem.dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
          cnt_d   = cnt_q + 16'd1;
          src_d   = src_q + WORD_STRIDE;
          dst_d   = dst_q + WORD_STRIDE;
          len_d   = len_q - 16'd1;
          // len_q still holds the count including the word just written
          state_d = (len_q == 16'd1) ? ST_DONE : ST_RD_REQ;
        end else if (dmem.dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign err             = err_q;
  assign xfer_cnt        = cnt_q;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_cmd   = cmd;
  assign dmem.dmem_width = SCR1_MEM_WIDTH_WORD;
  assign dmem.dmem_addr  = (cmd == SCR1_MEM_CMD_WR) ? dst_q : src_q;
  assign dmem.dmem_wdata = data_q;

endmodule

// File: tb/tb_scr1_dmem_copier.sv
// tb/tb_scr1_dmem_copier.sv - self-checking bench for scr1_dmem_copier with a scoreboarded memory responder
module tb_scr1_dmem_copier;
  import scr1_memif_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_src_addr;
  logic [31:0] cfg_dst_addr;
  logic [15:0] cfg_len;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] xfer_cnt;

  scr1_dmem_copier_if mif ();

  scr1_dmem_copier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_src_addr (cfg_src_addr),
    .cfg_dst_addr (cfg_dst_addr),
    .cfg_len      (cfg_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .xfer_cnt     (xfer_cnt),
    .dmem         (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  exp_t        sb[$];
  logic [31:0] wmem [logic [31:0]];
  int          ack_dly, resp_dly, err_rd, rd_idx, req_cycles, hold, rsp_left;
  logic        acked, rsp_pend, rsp_err;
  logic [31:0] rsp_data, first_addr, first_wdata;
  logic        first_cmd;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return {a[15:0] + 16'h1234, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                         input int a, input int r, input int erd, input bit mid_start);
    bit          misal;
    int          nwords, ntrans, exp_cyc, cyc;
    logic [15:0] exp_cnt;
    logic        exp_err;
    misal   = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
    nwords  = (misal || len == 16'd0) ? 0 : int'(len);
    exp_err = misal || (nwords > 0 && erd >= 0 && erd < nwords);
    exp_cnt = (nwords > 0 && exp_err) ? 16'(erd) : 16'(nwords);
    ntrans  = 0;
    sb.delete();
    for (int i = 0; i < nwords; i++) begin
      sb.push_back('{1'b0, src + 32'(4 * i), 32'd0});
      ntrans++;
      if (i == erd) break;
      sb.push_back('{1'b1, dst + 32'(4 * i), src_word(src + 32'(4 * i))});
      ntrans++;
    end
    exp_cyc = ntrans * (2 + a + r) + 1;
    ack_dly = a; resp_dly = r; err_rd = erd; rd_idx = 0; req_cycles = 0;

    @(negedge clk);
    cfg_src_addr = src; cfg_dst_addr = dst; cfg_len = len; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cyc = 1;
    chk("err_after_start", err, misal);
    while (!done && cyc < 400) begin
      if (mid_start && cyc == 3) begin
        cfg_start = 1'b1; cfg_src_addr = 32'h904; cfg_dst_addr = 32'hA00; cfg_len = 16'd7;
      end else begin
        cfg_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    chk("done_cycle", cyc, exp_cyc);
    chk("xfer_cnt", xfer_cnt, exp_cnt);
    chk("err_at_done", err, exp_err);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    chk("err_sticky", err, exp_err);
    chk("sb_drained", sb.size(), 0);
    chk("req_cycles", req_cycles, ntrans * (a + 1));
    for (int i = 0; i < int'(exp_cnt); i++)
      chk("copied_word", wmem[dst + 32'(4 * i)], src_word(src + 32'(4 * i)));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_src_addr = '0; cfg_dst_addr = '0; cfg_len = '0;
    mif.dmem_req_ack = 1'b0; mif.dmem_resp = SCR1_MEM_RESP_NOTRDY; mif.dmem_rdata = '0;
    ack_dly = 0; resp_dly = 0; err_rd = -1; rd_idx = 0; req_cycles = 0; hold = 0; rsp_left = 0;
    acked = 1'b0; rsp_pend = 1'b0; rsp_err = 1'b0; rsp_data = '0;
    first_addr = '0; first_wdata = '0; first_cmd = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mif.dmem_req_ack = 1'b0;
        mif.dmem_resp    = SCR1_MEM_RESP_NOTRDY;
        if (!rst_n) begin
          acked = 1'b0; rsp_pend = 1'b0; hold = 0;
        end else begin
          if (acked) begin
            rsp_pend = 1'b1; rsp_left = resp_dly; acked = 1'b0;
          end
          if (rsp_pend) begin
            if (rsp_left > 0) rsp_left--;
            else begin
              rsp_pend = 1'b0;
              mif.dmem_resp  = rsp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
              mif.dmem_rdata = rsp_data;
            end
          end
          if (mif.dmem_req) begin
            req_cycles++;
            if (hold == 0) begin
              first_cmd = mif.dmem_cmd; first_addr = mif.dmem_addr; first_wdata = mif.dmem_wdata;
            end else begin
              chk("hold_cmd", mif.dmem_cmd, first_cmd);
              chk("hold_addr", mif.dmem_addr, first_addr);
              if (first_cmd) chk("hold_wdata", mif.dmem_wdata, first_wdata);
            end
            if (hold < ack_dly) hold++;
            else begin
              exp_t e;
              hold = 0; acked = 1'b1; mif.dmem_req_ack = 1'b1;
              chk("width_word", mif.dmem_width, SCR1_MEM_WIDTH_WORD);
              chk("sb_avail", sb.size() != 0, 1'b1);
              if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("bus_cmd", mif.dmem_cmd == SCR1_MEM_CMD_WR, e.wr);
                chk("bus_addr", mif.dmem_addr, e.addr);
                if (e.wr) begin
                  chk("bus_wdata", mif.dmem_wdata, e.wdata);
                  wmem[mif.dmem_addr] = mif.dmem_wdata;
                  rsp_err = 1'b0;
                end else begin
                  rsp_err  = (rd_idx == err_rd);
                  rsp_data = src_word(mif.dmem_addr);
                  rd_idx++;
                end
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_xfer_cnt", xfer_cnt, 16'd0);
    chk("rst_req", mif.dmem_req, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(32'h100, 32'h200, 16'd3, 0, 0, -1, 1'b0);
    run_job(32'h300, 32'h400, 16'd2, 3, 2, -1, 1'b0);
    run_job(32'h500, 32'h600, 16'd4, 0, 0, 1, 1'b0);
    run_job(32'h540, 32'h640, 16'd1, 0, 0, -1, 1'b0);
    run_job(32'h102, 32'h200, 16'd3, 0, 0, -1, 1'b0);
    run_job(32'h100, 32'h201, 16'd2, 0, 0, -1, 1'b0);
    run_job(32'h100, 32'h200, 16'd0, 0, 0, -1, 1'b0);
    run_job(32'hFFFF_FFFC, 32'h700, 16'd2, 0, 0, -1, 1'b0);
    run_job(32'hC00, 32'hD00, 16'd2, 1, 1, -1, 1'b1);

    // abort a job while the first write request is being held off
    sb.delete();
    sb.push_back('{1'b0, 32'h800, 32'd0});
    sb.push_back('{1'b1, 32'h880, src_word(32'h800)});
    ack_dly = 3; resp_dly = 0; err_rd = -1; rd_idx = 0;
    @(negedge clk);
    cfg_src_addr = 32'h800; cfg_dst_addr = 32'h880; cfg_len = 16'd2; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    n = 0;
    while (!(mif.dmem_req && mif.dmem_cmd == SCR1_MEM_CMD_WR) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_req", mif.dmem_req && mif.dmem_cmd == SCR1_MEM_CMD_WR, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", mif.dmem_req, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_xfer_cnt", xfer_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    req_cycles = 0;
    repeat (5) @(negedge clk);
    chk("no_req_after_rst", req_cycles, 0);
    chk("idle_after_rst", busy, 1'b0);

    run_job(32'h800, 32'h880, 16'd2, 0, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
